// File: rtl/bcd_to_bin.sv
// bcd_to_bin: digit-serial signed BCD to binary converter; define BCD_CHECK_EN for the invalid-digit check and the dout_err port
module bcd_to_bin #(
  parameter int DIGITS = 6,
  parameter int DOUT_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din_sign,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  din_vld,
  output logic                  ready,
  output logic                  dout_sign,
  output logic [DOUT_W-1:0]     dout,
  output logic                  dout_vld
`ifdef BCD_CHECK_EN
  , output logic                dout_err
`endif
);
  localparam int IW = $clog2(DIGITS);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  typedef enum logic {IDLE, CALC} state_t;
  state_t state_q, state_d;
  logic [4*DIGITS-1:0] sr_q, sr_d;
  logic [DOUT_W-1:0] acc_q, acc_d, dout_q, dout_d, sum;
  logic [IW-1:0] idx_q, idx_d;
  logic sign_q, sign_d, dout_sign_q, dout_sign_d, dout_vld_q, dout_vld_d;
  logic err_q, err_d, err_n, dout_err_q, dout_err_d;
  logic [3:0] nib;
  always_comb begin
    nib = sr_q[4*DIGITS-1 -: 4];
    sum = (acc_q << 3) + (acc_q << 1) + DOUT_W'(nib);
`ifdef BCD_CHECK_EN
    err_n = err_q | (nib > 4'd9);
`else
    err_n = 1'b0;
`endif
    state_d = state_q;
    sr_d = sr_q;
    acc_d = acc_q;
    idx_d = idx_q;
    sign_d = sign_q;
    err_d = err_q;
    dout_d = dout_q;
    dout_sign_d = dout_sign_q;
    dout_err_d = dout_err_q;
    dout_vld_d = 1'b0;
    if (state_q == IDLE && din_vld) begin
      sr_d = din;
      sign_d = din_sign;
      acc_d = '0;
      idx_d = '0;
      err_d = 1'b0;
      state_d = CALC;
    end else if (state_q == CALC) begin
      sr_d = sr_q << 4;
      acc_d = sum;
      idx_d = idx_q + 1'b1;
      err_d = err_n;
      if (idx_q == LAST) begin
        dout_d = err_n ? '0 : sum;
        dout_sign_d = sign_q;
        dout_err_d = err_n;
        dout_vld_d = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q <= '0;
      acc_q <= '0;
      idx_q <= '0;
      sign_q <= 1'b0;
      err_q <= 1'b0;
      dout_q <= '0;
      dout_sign_q <= 1'b0;
      dout_err_q <= 1'b0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
      sign_q <= sign_d;
      err_q <= err_d;
      dout_q <= dout_d;
      dout_sign_q <= dout_sign_d;
      dout_err_q <= dout_err_d;
      dout_vld_q <= dout_vld_d;
    end
  end
  assign ready = (state_q == IDLE);
  assign dout = dout_q;
  assign dout_sign = dout_sign_q;
  assign dout_vld = dout_vld_q;
`ifdef BCD_CHECK_EN
  assign dout_err = dout_err_q;
`endif
endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: directed and random checks of bcd_to_bin against an arithmetic reference model
module tb_bcd_to_bin;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_sign = 1'b0;
  logic [23:0] din = '0;
  logic din_vld = 1'b0;
  logic ready, dout_sign, dout_vld;
  logic [23:0] dout;
`ifdef BCD_CHECK_EN
  logic dout_err;
`endif
  int n_chk = 0;
  int n_fail = 0;
  int cnt;
  bcd_to_bin #(.DIGITS(6), .DOUT_W(24)) dut (
    .clk(clk),
    .rst(rst),
    .din_sign(din_sign),
    .din(din),
    .din_vld(din_vld),
    .ready(ready),
    .dout_sign(dout_sign),
    .dout(dout),
    .dout_vld(dout_vld)
`ifdef BCD_CHECK_EN
    , .dout_err(dout_err)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic bit model_err(input logic [23:0] d);
    bit e = 0;
    for (int i = 0; i < 6; i++) if (d[4*i +: 4] > 4'd9) e = 1;
    return e;
  endfunction
  function automatic logic [23:0] model_val(input logic [23:0] d);
    int v = 0;
    for (int i = 5; i >= 0; i--) v = v * 10 + int'(d[4*i +: 4]);
`ifdef BCD_CHECK_EN
    if (model_err(d)) v = 0;
`endif
    return 24'(v);
  endfunction
  task automatic wait_vld(output int c);
    c = 0;
    do begin
      tick();
      c++;
      if (!dout_vld) chk("ready_busy", ready, 0);
    end while (!dout_vld && c < 20);
  endtask
  task automatic accept(input logic [23:0] d, input logic s);
    chk("ready_idle", ready, 1);
    din = d;
    din_sign = s;
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
  endtask
  task automatic check_result(input logic [23:0] d, input logic s);
    chk("dout_vld", dout_vld, 1);
    chk("ready_done", ready, 1);
    chk("dout", dout, model_val(d));
    chk("dout_sign", dout_sign, s);
`ifdef BCD_CHECK_EN
    chk("dout_err", dout_err, model_err(d));
`endif
  endtask
  task automatic convert(input logic [23:0] d, input logic s);
    int c;
    accept(d, s);
    wait_vld(c);
    chk("latency", c, 6);
    check_result(d, s);
    tick();
    chk("vld_pulse", dout_vld, 0);
    chk("dout_hold", dout, model_val(d));
  endtask
  initial begin
    logic [23:0] rd;
    tick();
    tick();
    chk("rst_ready", ready, 1);
    chk("rst_dout", dout, 0);
    chk("rst_vld", dout_vld, 0);
    chk("rst_sign", dout_sign, 0);
    rst = 1'b0;
    tick();
    convert(24'h254321, 1'b0);
    chk("ex_254321", dout, 254321);
    convert(24'h999999, 1'b1);
    chk("ex_999999", dout, 999999);
    convert(24'h000000, 1'b1);
    chk("neg_zero_sign", dout_sign, 1);
    accept(24'h000001, 1'b0);
    tick();
    tick();
    din = 24'h123456;
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    wait_vld(cnt);
    chk("drop_latency", cnt, 3);
    check_result(24'h000001, 1'b0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dout_vld) cnt++;
    end
    chk("drop_no_vld", cnt, 0);
    chk("drop_dout", dout, 1);
    accept(24'h000010, 1'b0);
    wait_vld(cnt);
    chk("b2b_lat1", cnt, 6);
    check_result(24'h000010, 1'b0);
    din = 24'h000100;
    din_sign = 1'b1;
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    chk("b2b_accepted", ready, 0);
    wait_vld(cnt);
    chk("b2b_lat2", cnt, 6);
    check_result(24'h000100, 1'b1);
    tick();
    accept(24'h123456, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_vld", dout_vld, 0);
    chk("abort_dout", dout, 0);
    chk("abort_sign", dout_sign, 0);
    chk("abort_ready", ready, 1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dout_vld) cnt++;
    end
    chk("abort_no_vld", cnt, 0);
    convert(24'h000005, 1'b0);
    convert(24'h00000A, 1'b0);
    convert(24'h12A456, 1'b0);
    convert(24'h000042, 1'b1);
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 6; i++)
        rd[4*i +: 4] = 4'($urandom_range(0, (k % 5 == 4) ? 15 : 9));
      convert(rd, 1'($urandom_range(0, 1)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
- Converts a signed 6-digit BCD temperature word {int tens, int ones, frac d0..d3} back to a 24-bit binary value scaled by 10000. Example: 25.4321 becomes 254321.
- Inverse of the binary-to-BCD display path. Used on the set-point / threshold entry path so that user-entered digits can be compared against the sensor's binary reading.
- Iterative digit-serial multiply-accumulate, one BCD nibble per clock, MSB first.

Parameters:
- DIGITS, 6, number of BCD nibbles in din (MSB nibble = int tens).
- DOUT_W, 24, binary output width; must satisfy 10^DIGITS-1 < 2^DOUT_W.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- din_sign  input  1  sign of the BCD word (1 = negative).
- din  input  4*DIGITS  BCD digits; din[4*DIGITS-1 -: 4] is the most significant.
- din_vld  input  1  one-cycle strobe; din and din_sign are valid with it.
- ready  output  1  high when a new din_vld will be accepted.
- dout_sign  output  1  registered sign belonging to dout.
- dout  output  DOUT_W  binary result.
- dout_vld  output  1  one-cycle strobe when dout and dout_sign update.
- dout_err  output  1  invalid-digit flag; present only with the optional feature.

Behaviour:
- Reset state: all outputs and internal registers are 0, state = IDLE, ready = 1.
- States:
  - IDLE: ready = 1.
  - CALC: ready = 0.
- Accept rule: din_vld sampled high in IDLE. At that edge:
  - capture din into a shift register and din_sign into a sign register;
  - clear acc and idx;
  - go to CALC.
- din_vld while in CALC is ignored. It is not queued, the current conversion is not disturbed, and no dout_vld is produced for the dropped word.
- CALC, each edge:
  - nib = top nibble of the shift register;
  - acc <= acc*10 + nib, with acc*10 formed as (acc<<3)+(acc<<1) at DOUT_W bits;
  - shift register moves left by 4;
  - idx <= idx+1.
- On the edge where idx = DIGITS-1:
  - dout <= acc*10 + nib;
  - dout_sign <= captured sign;
  - dout_vld <= 1;
  - state <= IDLE.
- dout_vld is high for exactly one cycle; otherwise it is 0.
- dout and dout_sign hold their value until the next completed conversion.
- Latency: dout_vld goes high DIGITS cycles after the accept edge (6 for the defaults). ready returns to 1 in the same cycle as dout_vld.
- A din_vld in the dout_vld cycle is accepted, giving back-to-back throughput of one word per DIGITS+1 cycles.
- Without the optional feature, digits above 9 are not checked: a nibble of 10..15 is accumulated arithmetically as its raw value.
- Sign is passed through unmodified, including negative zero (din_sign=1, din=0 → dout=0, dout_sign=1).
- Reset asserted during CALC:
  - aborts the conversion and returns to IDLE;
  - no dout_vld;
  - dout and dout_sign are cleared to 0.
- No overflow is possible for legal parameters, so there is no saturation logic.

Optional Feature:
- Macro: BCD_CHECK_EN.
- Defined:
  - each nibble is compared against 9 as it is consumed;
  - any nibble > 9 sets a sticky err bit for the current word;
  - at completion, dout_err <= err and dout <= 0 if err, else the result;
  - dout_sign is still updated;
  - dout_err resets to 0 and is updated only on completion;
  - err is cleared on accept.
- Not defined: the dout_err port does not exist, no digit checking is performed, and raw nibbles are accumulated.

Test Plan:
- Reset, then din=24'h254321, din_sign=0, one din_vld pulse → 6 cycles later dout=24'h03E171 (254321), dout_sign=0, dout_vld high 1 cycle; ready low for the 6 cycles in between.
- din=24'h999999, din_sign=1 → dout=24'h0F423F (999999), dout_sign=1; din=0, din_sign=1 → dout=0, dout_sign=1.
- Accept 24'h000001, then pulse din_vld with 24'h123456 three cycles later → only dout=1 is produced; dout is still 1 10 cycles later; no second dout_vld.
- Accept 24'h000010, then present 24'h000100 in the dout_vld cycle → dout=10, then 7 cycles later dout=100 (back-to-back accepted).
- Accept 24'h123456, assert rst for 1 cycle at cycle 3 → no dout_vld, dout=0, ready=1 next cycle; a following 24'h000005 converts to 5.
- BCD_CHECK_EN defined: din=24'h12A456 → dout=0, dout_err=1; next word 24'h000042 → dout=42, dout_err=0.
